// File: rtl/mod_mul_il_rk.sv
// rtl/mod_mul_il_rk.sv - radix-2^K interleaved modular multiplier, y = (a*b) mod m
//
// Scans a MSB-first, K bits per clock, keeping a running residue P < m.
// Operands are range-checked on acceptance; out-of-range operands give err=1, y=0.
//
// Ports:
//   clk         clock, all logic on the rising edge
//   rst         synchronous active-high reset; abandons any in-flight operation
//   in_valid    a/b/m valid
//   in_ready    block can accept operands (high only in IDLE)
//   a, b, m     multiplier (scanned MSB-first), multiplicand, modulus
//   out_valid   y/err valid, held until out_ready
//   out_ready   consumer accepts the result
//   y           result (a*b) mod m; 0 when err=1; keeps its value after retirement
//   err         operand out of range (m==0, a>=m or b>=m)
//   done_irq_p  one-cycle pulse on the first out_valid cycle of each result
module mod_mul_il_rk #(
    parameter int NBITS = 4096,
    parameter int K     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    input  logic [NBITS-1:0] m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] y,
    output logic             err,
    output logic             done_irq_p
);

    localparam int NDIG = NBITS / K;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (!(K == 1 || K == 2 || K == 4 || K == 8) || (NBITS % K) != 0) begin : g_bad_param
        $error("mod_mul_il_rk: K must be 1, 2, 4 or 8 and divide NBITS");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NBITS-1:0]  a_q, a_d;
    logic [NBITS-1:0]  b_q, b_d;
    logic [NBITS-1:0]  m_q, m_d;
    logic [NBITS-1:0]  y_q, y_d;
    logic [NBITS+1:0]  p_q, p_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              irq_q, irq_d;

    logic [NBITS+1:0]  p_step;
    logic [NBITS-1:0]  a_step;
    logic              bad_ops;

    // Two extra bits on P: before reduction 2P + b < 3m, so NBITS+2 bits never overflow,
    // and two conditional subtractions restore P < m.
    always_comb begin
        p_step = p_q;
        a_step = a_q;
        for (int j = 0; j < K; j++) begin
            p_step = {p_step[NBITS:0], 1'b0} + (a_step[NBITS-1] ? {2'b00, b_q} : '0);
            if (p_step >= {2'b00, m_q}) p_step = p_step - {2'b00, m_q};
            if (p_step >= {2'b00, m_q}) p_step = p_step - {2'b00, m_q};
            a_step = {a_step[NBITS-2:0], 1'b0};
        end
    end

    assign bad_ops = (m == '0) || (a >= m) || (b >= m);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        y_d     = y_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        irq_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d   = a;
                    b_d   = b;
                    m_d   = m;
                    p_d   = '0;
                    cnt_d = CW'(NDIG - 1);
                    if (bad_ops) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                        y_d     = '0;
                        irq_d   = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                p_d   = p_step;
                a_d   = a_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    y_d     = p_step[NBITS-1:0];
                    err_d   = 1'b0;
                    irq_d   = 1'b1;
                end
            end
            ST_DONE: begin
                // y is kept after retirement; only err is cleared.
                if (out_ready) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            y_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            y_q     <= y_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            irq_q   <= irq_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign y          = y_q;
    assign err        = err_q;
    assign done_irq_p = irq_q;

endmodule

// File: tb/tb_mod_mul_il_rk.sv
// tb/tb_mod_mul_il_rk.sv - scoreboard bench for mod_mul_il_rk (8-bit K=2/1/8 and 64-bit K=4)
module tb_mod_mul_il_rk;

    typedef struct {
        logic [63:0] y;
        logic        e;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // index 0: K=2, 1: K=1, 2: K=8 (all NBITS=8)
    logic       in_valid [3];
    logic       in_ready [3];
    logic       out_valid[3];
    logic       out_ready[3];
    logic       err      [3];
    logic       irq      [3];
    logic [7:0] a8       [3];
    logic [7:0] b8       [3];
    logic [7:0] m8       [3];
    logic [7:0] y8       [3];

    logic        iv64, ir64, ov64, or64, err64, irq64;
    logic [63:0] a64, b64, m64, y64;

    mod_mul_il_rk #(.NBITS(8), .K(2)) u_k2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a8[0]), .b(b8[0]), .m(m8[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .y(y8[0]), .err(err[0]), .done_irq_p(irq[0]));

    mod_mul_il_rk #(.NBITS(8), .K(1)) u_k1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a8[1]), .b(b8[1]), .m(m8[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .y(y8[1]), .err(err[1]), .done_irq_p(irq[1]));

    mod_mul_il_rk #(.NBITS(8), .K(8)) u_k8 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a8[2]), .b(b8[2]), .m(m8[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .y(y8[2]), .err(err[2]), .done_irq_p(irq[2]));

    mod_mul_il_rk #(.NBITS(64), .K(4)) u_r64 (
        .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64),
        .a(a64), .b(b64), .m(m64), .out_valid(ov64), .out_ready(or64),
        .y(y64), .err(err64), .done_irq_p(irq64));

    int   total = 0;
    int   bad   = 0;
    exp_t sq[4][$];
    int   n_ops  [4];
    int   pop_cnt[4];
    int   irq_cnt[4];
    logic prev_ov[4];
    int   irq_bad = 0;
    logic rdone;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [63:0] av, input logic [63:0] bv, input logic [63:0] mv);
        exp_t         r;
        logic [127:0] p;
        r.e = (mv == 64'd0) || (av >= mv) || (bv >= mv);
        r.y = 64'd0;
        if (!r.e) begin
            p   = {64'd0, av} * {64'd0, bv};
            r.y = 64'(p % {64'd0, mv});
        end
        return r;
    endfunction

    task automatic mon(input int i, input logic ov, input logic ordy, input logic [63:0] yy,
                       input logic ee, input logic ir);
        exp_t e;
        if (ir) irq_cnt[i]++;
        if (ir != (ov && !prev_ov[i])) irq_bad++;
        prev_ov[i] = ov;
        if (ov && ordy) begin
            if (sq[i].size() == 0) begin
                chk($sformatf("sb_extra%0d", i), 64'd1, 64'd0);
            end else begin
                e = sq[i].pop_front();
                chk($sformatf("sb_y%0d", i), yy, e.y);
                chk($sformatf("sb_err%0d", i), 64'(ee), 64'(e.e));
                pop_cnt[i]++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) prev_ov[i] = 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) mon(i, out_valid[i], out_ready[i], 64'(y8[i]), err[i], irq[i]);
            mon(3, ov64, or64, y64, err64, irq64);
        end
    end

    // Issues one 8-bit op; returns edges from the accepting edge to the first out_valid
    // cycle, plus the outputs seen in that cycle.
    task automatic op8(input int i, input logic [7:0] av, input logic [7:0] bv, input logic [7:0] mv,
                       output int lat, output logic [7:0] ry, output logic re, output logic rirq);
        int w;
        w = 0;
        while (!in_ready[i] && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 200) chk("ready_timeout", 64'd1, 64'd0);
        a8[i] = av; b8[i] = bv; m8[i] = mv;
        in_valid[i] = 1'b1;
        sq[i].push_back(model(64'(av), 64'(bv), 64'(mv)));
        n_ops[i]++;
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
        a8[i] = 8'($urandom()); b8[i] = 8'($urandom()); m8[i] = 8'($urandom());
        lat = 0;
        while (!out_valid[i] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        ry = y8[i]; re = err[i]; rirq = irq[i];
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int         lat;
        logic [7:0] ry;
        logic       re, ri;

        rst = 1'b1; rdone = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b1;
            a8[i] = '0; b8[i] = '0; m8[i] = '0;
        end
        for (int i = 0; i < 4; i++) begin
            n_ops[i] = 0; pop_cnt[i] = 0; irq_cnt[i] = 0; prev_ov[i] = 1'b0;
        end
        iv64 = 1'b0; or64 = 1'b1; a64 = '0; b64 = '0; m64 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_in_ready", 64'(in_ready[0]), 64'd1);
        chk("rst_out_valid", 64'(out_valid[0]), 64'd0);
        chk("rst_y", 64'(y8[0]), 64'd0);
        chk("rst_err", 64'(err[0]), 64'd0);
        chk("rst_irq", 64'(irq[0]), 64'd0);

        // basic case, K=2
        op8(0, 8'd7, 8'd9, 8'd13, lat, ry, re, ri);
        chk("k2_lat", 64'(lat), 64'd4);
        chk("k2_y", 64'(ry), 64'd11);
        chk("k2_err", 64'(re), 64'd0);
        chk("k2_irq", 64'(ri), 64'd1);

        op8(0, 8'd12, 8'd12, 8'd13, lat, ry, re, ri);
        chk("k2_y_12x12", 64'(ry), 64'd1);
        op8(0, 8'd0, 8'd5, 8'd13, lat, ry, re, ri);
        chk("k2_y_a0", 64'(ry), 64'd0);
        chk("k2_lat_a0", 64'(lat), 64'd4);
        op8(0, 8'd0, 8'd0, 8'd1, lat, ry, re, ri);
        chk("k2_m1_y", 64'(ry), 64'd0);
        chk("k2_m1_err", 64'(re), 64'd0);

        op8(1, 8'd7, 8'd9, 8'd13, lat, ry, re, ri);
        chk("k1_lat", 64'(lat), 64'd8);
        chk("k1_y", 64'(ry), 64'd11);
        op8(2, 8'd7, 8'd9, 8'd13, lat, ry, re, ri);
        chk("k8_lat", 64'(lat), 64'd1);
        chk("k8_y", 64'(ry), 64'd11);
        op8(2, 8'd255, 8'd254, 8'd255, lat, ry, re, ri);
        chk("k8_a_eq_m_err", 64'(re), 64'd1);

        // range errors: result in the accepting edge
        op8(0, 8'd13, 8'd3, 8'd13, lat, ry, re, ri);
        chk("err_lat", 64'(lat), 64'd0);
        chk("err_flag", 64'(re), 64'd1);
        chk("err_y", 64'(ry), 64'd0);
        chk("err_irq", 64'(ri), 64'd1);
        op8(0, 8'd2, 8'd3, 8'd0, lat, ry, re, ri);
        chk("err_m0", 64'(re), 64'd1);
        op8(0, 8'd2, 8'd13, 8'd13, lat, ry, re, ri);
        chk("err_b_eq_m", 64'(re), 64'd1);

        // back-pressure: result held, new operands ignored
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        op8(0, 8'd7, 8'd9, 8'd13, lat, ry, re, ri);
        chk("stall_lat", 64'(lat), 64'd4);
        for (int c = 0; c < 5; c++) begin
            a8[0] = 8'd1; b8[0] = 8'd1; m8[0] = 8'd13;
            in_valid[0] = c[0];
            @(posedge clk); #1;
            chk("stall_hold", {55'd0, out_valid[0], in_ready[0], y8[0]}, {55'd0, 1'b1, 1'b0, 8'd11});
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("retire_out_valid", 64'(out_valid[0]), 64'd0);
        chk("retire_in_ready", 64'(in_ready[0]), 64'd1);
        chk("retire_y_kept", 64'(y8[0]), 64'd11);
        chk("retire_err", 64'(err[0]), 64'd0);

        // reset mid-CALC abandons the op
        a8[0] = 8'd7; b8[0] = 8'd9; m8[0] = 8'd13;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", 64'(in_ready[0]), 64'd1);
        chk("midrst_out_valid", 64'(out_valid[0]), 64'd0);
        chk("midrst_y", 64'(y8[0]), 64'd0);
        op8(0, 8'd3, 8'd4, 8'd7, lat, ry, re, ri);
        chk("postrst_y", 64'(ry), 64'd5);
        chk("postrst_lat", 64'(lat), 64'd4);
        @(posedge clk); #1;

        // random 64-bit K=4 traffic
        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    int          gap;
                    int          w;
                    logic [63:0] av, bv, mv;
                    gap = int'($urandom_range(0, 3));
                    repeat (gap) begin
                        @(posedge clk); #1;
                    end
                    w = 0;
                    while (!ir64 && w < 500) begin
                        @(posedge clk); #1;
                        w++;
                    end
                    if (w >= 500) chk("r_ready_timeout", 64'd1, 64'd0);
                    mv = {$urandom(), $urandom()} >> $urandom_range(0, 63);
                    av = {$urandom(), $urandom()};
                    bv = {$urandom(), $urandom()};
                    if (mv != 64'd0 && $urandom_range(0, 15) != 0) begin
                        av = av % mv;
                        bv = bv % mv;
                    end
                    a64 = av; b64 = bv; m64 = mv;
                    iv64 = 1'b1;
                    sq[3].push_back(model(av, bv, mv));
                    n_ops[3]++;
                    @(posedge clk); #1;
                    iv64 = 1'b0;
                    a64 = {$urandom(), $urandom()};
                    b64 = {$urandom(), $urandom()};
                    m64 = {$urandom(), $urandom()};
                end
                for (int w = 0; w < 3000 && pop_cnt[3] < 1000; w++) begin
                    @(posedge clk); #1;
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk); #2;
                    or64 = ($urandom_range(0, 3) != 0);
                end
                or64 = 1'b1;
            end
        join

        repeat (3) @(posedge clk);
        #1;
        chk("rand_results", 64'(pop_cnt[3]), 64'd1000);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("irq_count%0d", i), 64'(irq_cnt[i]), 64'(n_ops[i]));
            chk($sformatf("sb_left%0d", i), 64'(sq[i].size()), 64'd0);
        end
        chk("irq_shape", 64'(irq_bad), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
